// File: rtl/mod_reduce_p25519_if.sv
// Handshake bundle between the GF(p) multiplier, the reducer and the register file.
// The producer/consumer side uses master, the reducer uses slave.
interface mod_reduce_p25519_if;
  logic         in_valid;
  logic         in_ready;
  logic [509:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [254:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mod_reduce_p25519.sv
// Sequential reducer of a 510-bit product modulo p = 2^255 - 19, folding the high half
// with 2^255 == 19 one LIMB_W-bit slice per cycle, then one conditional subtraction.
module mod_reduce_p25519 #(
  parameter int unsigned LIMB_W = 51
) (
  input logic                 clk,
  input logic                 rst,
  mod_reduce_p25519_if.slave  bus
);

  localparam int unsigned NLIMB = 255 / LIMB_W;
  localparam int unsigned CntW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  // 19*slice + slice + carry(<=19) stays below 2^(LIMB_W+5)
  localparam int unsigned SW    = LIMB_W + 5;
  localparam logic [255:0] P    = {1'b0, {250{1'b1}}, 5'b01101};

  typedef enum logic [2:0] {StIdle, StFold, StTop, StFinal, StDone} state_e;

  state_e          state_q;
  logic [254:0]    l_q, h_q, acc_q;
  logic [255:0]    r_q;
  logic [4:0]      carry_q;
  logic [CntW-1:0] cnt_q;
  logic            in_ready_q, out_valid_q;
  logic [254:0]    out_data_q;

  logic [SW-1:0]         s;
  logic [255+LIMB_W-1:0] acc_cat;
  logic [254:0]          acc_next;
  logic [9:0]            c19;
  logic [255:0]          r_d;
  logic [255:0]          t;
  logic [254:0]          red;

  always_comb begin
    s        = SW'(l_q[LIMB_W-1:0]) + SW'(h_q[LIMB_W-1:0]) * SW'(19) + SW'(carry_q);
    // Slices enter at the top and shift down, so after NLIMB cycles slice 0 sits at bit 0
    acc_cat  = {s[LIMB_W-1:0], acc_q};
    acc_next = acc_cat[255+LIMB_W-1:LIMB_W];
    c19      = {5'b0, carry_q} * 10'd19;
    r_d      = {1'b0, acc_q} + 256'(c19);
    t        = {1'b0, r_q[254:0]} + (r_q[255] ? 256'd19 : 256'd0);
    red      = (t >= P) ? 255'(t - P) : t[254:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      l_q         <= '0;
      h_q         <= '0;
      acc_q       <= '0;
      r_q         <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            l_q        <= bus.in_data[254:0];
            h_q        <= bus.in_data[509:255];
            cnt_q      <= '0;
            carry_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StFold;
          end
        end
        StFold: begin
          acc_q   <= acc_next;
          l_q     <= l_q >> LIMB_W;
          h_q     <= h_q >> LIMB_W;
          carry_q <= s[LIMB_W+4:LIMB_W];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CntW'(NLIMB - 1)) state_q <= StTop;
        end
        StTop: begin
          r_q     <= r_d;
          state_q <= StFinal;
        end
        StFinal: begin
          out_data_q  <= red;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_mod_reduce_p25519.sv
// Bench for mod_reduce_p25519: directed corner values, stall, mid-job reset, and random
// products against x % p at four slice widths.
module tb_mod_reduce_p25519;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_reduce_p25519_if u_if51 ();
  mod_reduce_p25519_if u_if15 ();
  mod_reduce_p25519_if u_if17 ();
  mod_reduce_p25519_if u_if255 ();

  mod_reduce_p25519 #(.LIMB_W(51))  u_dut51  (.clk(clk), .rst(rst), .bus(u_if51));
  mod_reduce_p25519 #(.LIMB_W(15))  u_dut15  (.clk(clk), .rst(rst), .bus(u_if15));
  mod_reduce_p25519 #(.LIMB_W(17))  u_dut17  (.clk(clk), .rst(rst), .bus(u_if17));
  mod_reduce_p25519 #(.LIMB_W(255)) u_dut255 (.clk(clk), .rst(rst), .bus(u_if255));

  int n_cmp = 0;
  int n_err = 0;
  logic [511:0] p_big;
  logic [511:0] one = 512'd1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [509:0] rand_x();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    if ($urandom_range(0, 7) == 0) v[509:255] = '1;
    return v[509:0];
  endfunction

  // One job on the LIMB_W=51 instance with out_ready held high.
  task automatic run_job(input logic [509:0] x, input logic [254:0] exp, input string tag);
    int n;
    chk({tag, "_in_ready"}, 512'(u_if51.in_ready), 512'd1);
    u_if51.in_data  = x;
    u_if51.in_valid = 1'b1;
    step();
    u_if51.in_valid = 1'b0;
    n = 0;
    while (!u_if51.out_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 512'(n), 512'd7);
    chk({tag, "_data"}, 512'(u_if51.out_data), 512'(exp));
    step();
    chk({tag, "_valid_drop"}, 512'(u_if51.out_valid), 512'd0);
    chk({tag, "_ready_back"}, 512'(u_if51.in_ready), 512'd1);
  endtask

  initial begin
    logic [509:0] x;
    logic [254:0] exp;
    logic [3:0]   got;
    logic [254:0] res [4];
    int n;

    p_big = (one << 255) - 512'd19;
    rst = 1'b1;
    u_if51.in_valid  = 1'b0; u_if51.in_data  = '0; u_if51.out_ready  = 1'b1;
    u_if15.in_valid  = 1'b0; u_if15.in_data  = '0; u_if15.out_ready  = 1'b1;
    u_if17.in_valid  = 1'b0; u_if17.in_data  = '0; u_if17.out_ready  = 1'b1;
    u_if255.in_valid = 1'b0; u_if255.in_data = '0; u_if255.out_ready = 1'b1;
    repeat (3) step();
    chk("reset_in_ready", 512'(u_if51.in_ready), 512'd1);
    chk("reset_out_valid", 512'(u_if51.out_valid), 512'd0);
    chk("reset_out_data", 512'(u_if51.out_data), 512'd0);
    rst = 1'b0;
    step();

    run_job(510'd0, 255'd0, "x0");
    run_job(510'd1, 255'd1, "x1");
    run_job(510'd18, 255'd18, "x18");
    run_job(p_big[509:0], 255'd0, "xp");
    run_job(510'(p_big + 512'd5), 255'd5, "xp5");
    run_job(510'(p_big * 512'd2), 255'd0, "x2p");
    run_job(510'(one << 255), 255'd19, "x2_255");
    run_job({510{1'b1}}, 255'd360, "xmax");
    run_job(510'((p_big - 512'd1) * (p_big - 512'd1)), 255'd1, "xpm1sq");
    run_job(510'(one << 256), 255'd38, "x2_256");

    // Output stall with junk on the input side
    x   = rand_x();
    exp = 255'(512'(x) % p_big);
    u_if51.out_ready = 1'b0;
    u_if51.in_data   = x;
    u_if51.in_valid  = 1'b1;
    step();
    u_if51.in_valid = 1'b0;
    n = 0;
    while (!u_if51.out_valid && n < 50) begin
      step();
      n++;
    end
    chk("stall_latency", 512'(n), 512'd7);
    chk("stall_data", 512'(u_if51.out_data), 512'(exp));
    for (int c = 0; c < 10; c++) begin
      u_if51.in_valid = 1'($urandom_range(0, 1));
      u_if51.in_data  = rand_x();
      step();
      chk("stall_hold_data", 512'(u_if51.out_data), 512'(exp));
      chk("stall_hold_valid", 512'(u_if51.out_valid), 512'd1);
      chk("stall_in_ready", 512'(u_if51.in_ready), 512'd0);
    end
    u_if51.in_valid  = 1'b0;
    u_if51.out_ready = 1'b1;
    step();
    chk("stall_release_valid", 512'(u_if51.out_valid), 512'd0);
    chk("stall_release_ready", 512'(u_if51.in_ready), 512'd1);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("stall_no_second_job", 512'({u_if51.out_valid, u_if51.in_ready}), 512'b01);
    end

    // Reset during FOLD slice i=2
    u_if51.in_data  = 510'(one << 255);
    u_if51.in_valid = 1'b1;
    step();
    u_if51.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 512'(u_if51.in_ready), 512'd1);
    chk("abort_out_valid", 512'(u_if51.out_valid), 512'd0);
    chk("abort_out_data", 512'(u_if51.out_data), 512'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("abort_no_output", 512'(u_if51.out_valid), 512'd0);
    end
    run_job(510'(one << 255), 255'd19, "post_abort");

    // Random products, all four slice widths in parallel
    for (int j = 0; j < 500; j++) begin
      x   = rand_x();
      exp = 255'(512'(x) % p_big);
      u_if51.in_data = x; u_if15.in_data = x; u_if17.in_data = x; u_if255.in_data = x;
      u_if51.in_valid = 1'b1; u_if15.in_valid = 1'b1;
      u_if17.in_valid = 1'b1; u_if255.in_valid = 1'b1;
      step();
      u_if51.in_valid = 1'b0; u_if15.in_valid = 1'b0;
      u_if17.in_valid = 1'b0; u_if255.in_valid = 1'b0;
      got = '0;
      for (int k = 0; k < 4; k++) res[k] = 'x;
      for (int c = 0; c < 40 && got != 4'hf; c++) begin
        step();
        if (u_if15.out_valid && !got[0])  begin got[0] = 1'b1; res[0] = u_if15.out_data;  end
        if (u_if17.out_valid && !got[1])  begin got[1] = 1'b1; res[1] = u_if17.out_data;  end
        if (u_if51.out_valid && !got[2])  begin got[2] = 1'b1; res[2] = u_if51.out_data;  end
        if (u_if255.out_valid && !got[3]) begin got[3] = 1'b1; res[3] = u_if255.out_data; end
      end
      chk("rnd_all_done", 512'(got), 512'hf);
      chk("rnd_w15", 512'(res[0]), 512'(exp));
      chk("rnd_w17", 512'(res[1]), 512'(exp));
      chk("rnd_w51", 512'(res[2]), 512'(exp));
      chk("rnd_w255", 512'(res[3]), 512'(exp));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
